frame_luma_stats: RTL and testbench

Per-frame luminance statistics stage that sits directly upstream of the brightness/dark-enhancement curve block. It converts the incoming RGB888 stream to 8-bit luma and accumulates pixel count, luma sum, minimum, maximum and dark-pixel count over each frame. At every frame boundary it publishes the frame average (computed by a sequential divider) together with the other statistics. It also forwards the video stream, delay-matched, to the curve stage.

---
 rtl/frame_luma_stats.sv | 212 +++++++++++++++++++++
 tb/tb_frame_luma_stats.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_luma_stats.sv
// Per-frame luma statistics (count, average, min, max, dark count) with a 2-cycle
// delay-matched stream passthrough. Define FLS_DARK_CNT_EN to include the dark-pixel counter.
module frame_luma_stats #(
    parameter int CNT_W   = 22,
    parameter int DARK_TH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [23:0]      i_rgb,
    input  logic             i_de,
    input  logic             i_vs,
    input  logic             i_hs,
    output logic [23:0]      o_rgb,
    output logic             o_de,
    output logic             o_vs,
    output logic             o_hs,
    output logic [7:0]       o_avg_y,
    output logic [7:0]       o_min_y,
    output logic [7:0]       o_max_y,
    output logic [CNT_W-1:0] o_dark_cnt,
    output logic [CNT_W-1:0] o_pix_cnt,
    output logic             o_stat_valid,
    output logic             o_drop
);
    localparam int SUM_W = CNT_W + 8;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    logic [23:0] rgb_d1_q, rgb_d2_q;
    logic        de_d1_q, de_d2_q, vs_d1_q, vs_o_q, hs_d1_q, hs_d2_q;
    logic [15:0] prod_r_q, prod_g_q, prod_b_q;
    logic [15:0] y_full;
    logic [7:0]  y_q;
    logic        y_valid_q, vs_d2_q, vs_d3_q, fe;

    // Stream path is deliberately unreset so the 2-cycle latency holds through reset.
    always_ff @(posedge clk) begin
        rgb_d1_q <= i_rgb;
        rgb_d2_q <= rgb_d1_q;
        de_d1_q  <= i_de;
        de_d2_q  <= de_d1_q;
        vs_d1_q  <= i_vs;
        vs_o_q   <= vs_d1_q;
        hs_d1_q  <= i_hs;
        hs_d2_q  <= hs_d1_q;
        prod_r_q <= 16'(i_rgb[23:16]) * 16'd77;
        prod_g_q <= 16'(i_rgb[15:8]) * 16'd150;
        prod_b_q <= 16'(i_rgb[7:0]) * 16'd29;
        y_q      <= 8'(y_full >> 8);
    end

    assign y_full = prod_r_q + prod_g_q + prod_b_q;
    assign o_rgb  = rgb_d2_q;
    assign o_de   = de_d2_q;
    assign o_vs   = vs_o_q;
    assign o_hs   = hs_d2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_valid_q <= 1'b0;
            vs_d2_q   <= 1'b0;
            vs_d3_q   <= 1'b0;
        end else begin
            y_valid_q <= de_d1_q;
            vs_d2_q   <= vs_d1_q;
            vs_d3_q   <= vs_d2_q;
        end
    end

    assign fe = vs_d2_q & ~vs_d3_q;

    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, cnt_base;
    logic [SUM_W-1:0] sum_q, sum_d, sum_base;
    logic [SUM_W:0]   sum_ext;
    logic [7:0]       min_q, min_d, min_base, max_q, max_d, max_base;
`ifdef FLS_DARK_CNT_EN
    localparam logic [8:0] DARK_TH_V = 9'(DARK_TH);
    logic [CNT_W-1:0] dark_q, dark_d, dark_base, sh_dark_q;
`endif

    // A frame-end reload and a same-cycle pixel combine: the pixel opens the new frame.
    always_comb begin
        cnt_base  = fe ? '0 : pix_cnt_q;
        sum_base  = fe ? '0 : sum_q;
        min_base  = fe ? 8'hFF : min_q;
        max_base  = fe ? 8'h00 : max_q;
        pix_cnt_d = cnt_base;
        sum_d     = sum_base;
        min_d     = min_base;
        max_d     = max_base;
        sum_ext   = {1'b0, sum_base} + {{(CNT_W + 1){1'b0}}, y_q};
`ifdef FLS_DARK_CNT_EN
        dark_base = fe ? '0 : dark_q;
        dark_d    = dark_base;
`endif
        if (y_valid_q) begin
            pix_cnt_d = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
            sum_d     = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
            min_d     = (y_q < min_base) ? y_q : min_base;
            max_d     = (y_q > max_base) ? y_q : max_base;
`ifdef FLS_DARK_CNT_EN
            if (({1'b0, y_q} < DARK_TH_V) && !(&dark_base))
                dark_d = dark_base + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt_q <= '0;
            sum_q     <= '0;
            min_q     <= 8'hFF;
            max_q     <= 8'h00;
`ifdef FLS_DARK_CNT_EN
            dark_q    <= '0;
`endif
        end else begin
            pix_cnt_q <= pix_cnt_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
`ifdef FLS_DARK_CNT_EN
            dark_q    <= dark_d;
`endif
        end
    end

    state_t           state_q;
    logic [CNT_W-1:0] sh_cnt_q, rem_q, rem_d;
    logic [7:0]       sh_min_q, sh_max_q, lo_q, quot_q;
    logic [2:0]       bit_cnt_q;
    logic             ovf_q, cnt_zero, div_ge;
    logic [CNT_W:0]   trial, diff;

    // Quotient is known to fit 8 bits, so the upper sum bits seed the remainder directly.
    assign cnt_zero = (sh_cnt_q == '0);
    assign trial    = {rem_q, lo_q[7]};
    assign diff     = trial - {1'b0, sh_cnt_q};
    assign div_ge   = (trial >= {1'b0, sh_cnt_q});
    assign rem_d    = CNT_W'(div_ge ? diff : trial);
    assign o_drop   = fe & (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sh_cnt_q     <= '0;
            sh_min_q     <= 8'h00;
            sh_max_q     <= 8'h00;
            rem_q        <= '0;
            lo_q         <= 8'h00;
            quot_q       <= 8'h00;
            bit_cnt_q    <= 3'd0;
            ovf_q        <= 1'b0;
            o_avg_y      <= 8'h00;
            o_min_y      <= 8'h00;
            o_max_y      <= 8'h00;
            o_pix_cnt    <= '0;
            o_stat_valid <= 1'b0;
`ifdef FLS_DARK_CNT_EN
            sh_dark_q    <= '0;
            o_dark_cnt   <= '0;
`endif
        end else begin
            o_stat_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fe) begin
                        sh_cnt_q  <= pix_cnt_q;
                        sh_min_q  <= min_q;
                        sh_max_q  <= max_q;
                        rem_q     <= sum_q[SUM_W-1:8];
                        lo_q      <= sum_q[7:0];
                        ovf_q     <= (sum_q[SUM_W-1:8] >= pix_cnt_q);
                        quot_q    <= 8'h00;
                        bit_cnt_q <= 3'd0;
`ifdef FLS_DARK_CNT_EN
                        sh_dark_q <= dark_q;
`endif
                        state_q   <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (!cnt_zero && !ovf_q) begin
                        rem_q  <= rem_d;
                        quot_q <= {quot_q[6:0], div_ge};
                    end
                    lo_q      <= lo_q << 1;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    o_avg_y      <= cnt_zero ? 8'h00 : (ovf_q ? 8'hFF : quot_q);
                    o_min_y      <= cnt_zero ? 8'h00 : sh_min_q;
                    o_max_y      <= cnt_zero ? 8'h00 : sh_max_q;
                    o_pix_cnt    <= sh_cnt_q;
`ifdef FLS_DARK_CNT_EN
                    o_dark_cnt   <= sh_dark_q;
`endif
                    o_stat_valid <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifndef FLS_DARK_CNT_EN
    assign o_dark_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_luma_stats.sv
// Self-checking bench for frame_luma_stats: table-driven frames, scoreboarded stat publishes,
// drop/reset/same-cycle corner sequences and a continuous passthrough delay check.
module tb_frame_luma_stats;
    localparam int CNT_W = 22;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [23:0]      i_rgb = 24'h0;
    logic             i_de = 1'b0, i_vs = 1'b0, i_hs = 1'b0;
    logic [23:0]      o_rgb;
    logic             o_de, o_vs, o_hs;
    logic [7:0]       o_avg_y, o_min_y, o_max_y;
    logic [CNT_W-1:0] o_dark_cnt, o_pix_cnt;
    logic             o_stat_valid, o_drop;

    frame_luma_stats #(.CNT_W(CNT_W), .DARK_TH(64)) dut (
        .clk(clk), .rst_n(rst_n), .i_rgb(i_rgb), .i_de(i_de), .i_vs(i_vs), .i_hs(i_hs),
        .o_rgb(o_rgb), .o_de(o_de), .o_vs(o_vs), .o_hs(o_hs),
        .o_avg_y(o_avg_y), .o_min_y(o_min_y), .o_max_y(o_max_y),
        .o_dark_cnt(o_dark_cnt), .o_pix_cnt(o_pix_cnt),
        .o_stat_valid(o_stat_valid), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int avg; int mn; int mx; int pix; int dark; } exp_t;
    typedef struct { logic [3:0][23:0] rgb; int ncol; int rep;
                     int avg; int mn; int mx; int pix; int dark; } vec_t;

    int     cyc = 0;
    int     n_cmp = 0, n_fail = 0;
    int     last_rise = -100;
    int     rc;
    bit     chk_en = 1'b0;
    exp_t   sb_q[$];
    int     drop_q[$];
    exp_t   held = '{0, 0, 0, 0, 0, 0};
    exp_t   e;
    bit     exp_v, exp_d;
    logic [26:0] h1, h2;
    vec_t   vecs[6];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        h1  <= {i_rgb, i_de, i_vs, i_hs};
        h2  <= h1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int dk(input int d);
`ifdef FLS_DARK_CNT_EN
        return d;
`else
        return 0;
`endif
    endfunction

    // Passthrough, publish timing/values, hold between publishes and drop pulses.
    always @(negedge clk) begin
        if (cyc >= 3)
            check("passthrough", {5'd0, o_rgb, o_de, o_vs, o_hs}, {5'd0, h2});
        if (chk_en) begin
            exp_v = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
            check("stat_valid", {31'd0, o_stat_valid}, {31'd0, exp_v});
            if (exp_v) begin
                e = sb_q.pop_front();
                held = e;
                $display("stat @%0d avg=%0d min=%0d max=%0d pix=%0d dark=%0d",
                         cyc, o_avg_y, o_min_y, o_max_y, o_pix_cnt, o_dark_cnt);
            end
            check("avg_y", {24'd0, o_avg_y}, held.avg);
            check("min_y", {24'd0, o_min_y}, held.mn);
            check("max_y", {24'd0, o_max_y}, held.mx);
            check("pix_cnt", {10'd0, o_pix_cnt}, held.pix);
            check("dark_cnt", {10'd0, o_dark_cnt}, dk(held.dark));
            exp_d = (drop_q.size() > 0) && (drop_q[0] == cyc);
            if (exp_d) void'(drop_q.pop_front());
            check("drop", {31'd0, o_drop}, {31'd0, exp_d});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            i_de  = 1'b0;
            i_vs  = 1'b0;
            i_rgb = 24'($urandom);
            i_hs  = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic pixel(input logic [23:0] rgb);
        i_de  = 1'b1;
        i_vs  = 1'b0;
        i_rgb = rgb;
        i_hs  = 1'b0;
        tick();
    endtask

    // Rising vs closes the current frame; its publish is due 12 cycles after the drive cycle.
    task automatic vs_rise(input bit de, input logic [23:0] rgb, input bit push, input bit nopad,
                           input int avg, input int mn, input int mx, input int pix,
                           input int dark, output int rise_cyc);
        if (!nopad)
            while (cyc - last_rise < 12) idle(1);
        i_vs  = 1'b1;
        i_de  = de;
        i_rgb = rgb;
        rise_cyc = cyc;
        last_rise = cyc;
        if (push) sb_q.push_back('{cyc + 12, avg, mn, mx, pix, dark});
        tick();
        i_de = 1'b0;
        tick();
        i_vs = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_avg", {24'd0, o_avg_y}, 0);
        check("rst_min", {24'd0, o_min_y}, 0);
        check("rst_max", {24'd0, o_max_y}, 0);
        check("rst_pix", {10'd0, o_pix_cnt}, 0);
        check("rst_dark", {10'd0, o_dark_cnt}, 0);
        check("rst_valid", {31'd0, o_stat_valid}, 0);
        check("rst_drop", {31'd0, o_drop}, 0);
    endtask

    initial begin
        vecs[0] = '{{24'h0, 24'h0, 24'h0, 24'h808080}, 1, 64, 128, 128, 128, 64, 0};
        vecs[1] = '{{24'h0, 24'h0000FF, 24'h00FF00, 24'hFF0000}, 3, 1, 84, 28, 149, 3, 1};
        vecs[2] = '{{24'h0, 24'h0, 24'h0, 24'h000000}, 1, 5, 0, 0, 0, 5, 5};
        vecs[3] = '{{24'h0, 24'h0, 24'h0, 24'hFFFFFF}, 1, 2, 255, 255, 255, 2, 0};
        vecs[4] = '{{24'h3F3F3F, 24'h404040, 24'h404040, 24'h404040}, 4, 1, 63, 63, 64, 4, 1};
        vecs[5] = '{{24'h0, 24'h0, 24'hC08040, 24'h102030}, 2, 1, 84, 29, 140, 2, 1};

        // Reset state
        rst_n = 1'b0;
        tick(); tick(); tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // First frame boundary after reset: no pixels seen yet
        vs_rise(1'b0, 24'h0, 1'b1, 1'b0, 0, 0, 0, 0, 0, rc);

        foreach (vecs[v]) begin
            for (int r = 0; r < vecs[v].rep; r++)
                for (int c = 0; c < vecs[v].ncol; c++) begin
                    pixel(vecs[v].rgb[c]);
                    if (((r * vecs[v].ncol + c) % 8) == 7) idle(1);
                end
            vs_rise(1'b0, 24'h0, 1'b1, 1'b0, vecs[v].avg, vecs[v].mn, vecs[v].mx,
                    vecs[v].pix, vecs[v].dark, rc);
        end

        // Empty frame: all-zero publish, no drop
        vs_rise(1'b0, 24'h0, 1'b1, 1'b0, 0, 0, 0, 0, 0, rc);

        // Two vs rises 5 cycles apart: second frame discarded with a drop pulse
        pixel(24'h808080);
        pixel(24'h808080);
        vs_rise(1'b0, 24'h0, 1'b1, 1'b0, 128, 128, 128, 2, 0, rc);
        idle(2);
        drop_q.push_back(cyc + 2);
        vs_rise(1'b0, 24'h0, 1'b0, 1'b1, 0, 0, 0, 0, 0, rc);
        pixel(24'hC08040);
        pixel(24'h102030);
        vs_rise(1'b0, 24'h0, 1'b1, 1'b0, 84, 29, 140, 2, 1, rc);

        // Pixel in the same cycle as the vs rise belongs to the new frame
        pixel(24'h000000);
        pixel(24'h000000);
        vs_rise(1'b1, 24'hFFFFFF, 1'b1, 1'b0, 0, 0, 0, 2, 2, rc);
        vs_rise(1'b0, 24'h0, 1'b1, 1'b0, 255, 255, 255, 1, 0, rc);

        // Reset while dividing: no publish, outputs cleared
        pixel(24'h808080);
        pixel(24'h808080);
        pixel(24'h808080);
        vs_rise(1'b0, 24'h0, 1'b0, 1'b0, 0, 0, 0, 0, 0, rc);
        idle(3);
        chk_en = 1'b0;
        rst_n = 1'b0;
        tick();
        check_reset_outputs();
        sb_q.delete();
        drop_q.delete();
        held = '{0, 0, 0, 0, 0, 0};
        idle(2);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;
        idle(12);

        // First frame after that reset
        pixel(24'hFFFFFF);
        pixel(24'h000000);
        vs_rise(1'b0, 24'h0, 1'b1, 1'b0, 127, 0, 255, 2, 1, rc);
        idle(20);

        check("pending_stats", sb_q.size(), 0);
        check("pending_drops", drop_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
